// File: rtl/vehicle_sense_cond.sv
// Loop-detector conditioning for a four-approach intersection: debounces each raw
// loop, holds presence across short gaps, flags stuck loops and counts arrivals.
module vehicle_sense_cond #(
  parameter int DEB   = 3,
  parameter int HOLD  = 4,
  parameter int STUCK = 60
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       loop_n,
  input  logic       loop_e,
  input  logic       loop_s,
  input  logic       loop_w,
  input  logic       clr_cnt,
  output logic       sensor_north,
  output logic       sensor_east,
  output logic       sensor_south,
  output logic       sensor_west,
  output logic [7:0] veh_cnt_n,
  output logic [7:0] veh_cnt_e,
  output logic [7:0] veh_cnt_s,
  output logic [7:0] veh_cnt_w,
  output logic [3:0] fault
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUAL    = 3'd1,
    S_PRESENT = 3'd2,
    S_GAP     = 3'd3,
    S_FAULT   = 3'd4
  } chan_state_t;

  localparam int QW = $clog2(DEB + 1);
  localparam int GW = $clog2(HOLD + 1);
  localparam int OW = $clog2(STUCK + 1);

  localparam logic [QW-1:0] DEB_M1   = QW'(DEB - 1);
  localparam logic [GW-1:0] HOLD_M1  = GW'(HOLD - 1);
  localparam logic [OW-1:0] STUCK_M1 = OW'(STUCK - 1);

  logic [3:0] raw;
  logic [3:0] sensor_vec;
  logic [3:0] fault_vec;
  logic [7:0] cnt_vec [4];

  assign raw = {loop_w, loop_s, loop_e, loop_n};

  // Each channel's FSM state is the per-block signal g_chan[i].state_q.
  for (genvar i = 0; i < 4; i++) begin : g_chan
    chan_state_t   state_q, state_d;
    logic [QW-1:0] qual_q, qual_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [OW-1:0] on_q, on_d;
    logic          arrival;
    logic          sensor_q;
    logic          fault_q;
    logic [7:0]    cnt_q;

    // qual_* doubles as the clear-qualify count while in FAULT.
    always_comb begin
      state_d = state_q;
      qual_d  = qual_q;
      gap_d   = gap_q;
      on_d    = on_q;
      arrival = 1'b0;
      if (tick) begin
        case (state_q)
          S_IDLE: begin
            if (raw[i]) begin
              if (DEB == 1) begin
                state_d = S_PRESENT;
                qual_d  = '0;
                on_d    = '0;
                arrival = 1'b1;
              end else begin
                state_d = S_QUAL;
                qual_d  = QW'(1);
              end
            end
          end
          S_QUAL: begin
            if (!raw[i]) begin
              state_d = S_IDLE;
              qual_d  = '0;
            end else if (qual_q == DEB_M1) begin
              state_d = S_PRESENT;
              qual_d  = '0;
              on_d    = '0;
              arrival = 1'b1;
            end else begin
              qual_d = qual_q + 1'b1;
            end
          end
          S_PRESENT: begin
            if (raw[i]) begin
              if (on_q == STUCK_M1) begin
                state_d = S_FAULT;
                on_d    = '0;
                qual_d  = '0;
              end else begin
                on_d = on_q + 1'b1;
              end
            end else if (HOLD == 1) begin
              state_d = S_IDLE;
              on_d    = '0;
            end else begin
              state_d = S_GAP;
              gap_d   = GW'(1);
            end
          end
          S_GAP: begin
            if (raw[i]) begin
              state_d = S_PRESENT;
              gap_d   = '0;
            end else if (gap_q == HOLD_M1) begin
              state_d = S_IDLE;
              gap_d   = '0;
              on_d    = '0;
            end else begin
              gap_d = gap_q + 1'b1;
            end
          end
          S_FAULT: begin
            if (raw[i]) begin
              qual_d = '0;
            end else if (qual_q == DEB_M1) begin
              state_d = S_IDLE;
              qual_d  = '0;
            end else begin
              qual_d = qual_q + 1'b1;
            end
          end
          default: begin
            state_d = S_IDLE;
            qual_d  = '0;
            gap_d   = '0;
            on_d    = '0;
          end
        endcase
      end
    end

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q  <= S_IDLE;
        qual_q   <= '0;
        gap_q    <= '0;
        on_q     <= '0;
        sensor_q <= 1'b0;
        fault_q  <= 1'b0;
      end else begin
        state_q  <= state_d;
        qual_q   <= qual_d;
        gap_q    <= gap_d;
        on_q     <= on_d;
        sensor_q <= (state_d inside {S_PRESENT, S_GAP, S_FAULT});
        fault_q  <= (state_d == S_FAULT);
      end
    end

    // A clear wins over a coincident arrival.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q <= 8'd0;
      end else if (clr_cnt) begin
        cnt_q <= 8'd0;
      end else if (arrival && (cnt_q != 8'hFF)) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end

    assign sensor_vec[i] = sensor_q;
    assign fault_vec[i]  = fault_q;
    assign cnt_vec[i]    = cnt_q;
  end

  assign sensor_north = sensor_vec[0];
  assign sensor_east  = sensor_vec[1];
  assign sensor_south = sensor_vec[2];
  assign sensor_west  = sensor_vec[3];
  assign veh_cnt_n    = cnt_vec[0];
  assign veh_cnt_e    = cnt_vec[1];
  assign veh_cnt_s    = cnt_vec[2];
  assign veh_cnt_w    = cnt_vec[3];
  assign fault        = fault_vec;

endmodule

// File: tb/tb_vehicle_sense_cond.sv
// Bench for vehicle_sense_cond: directed scenarios plus random traffic, all checked
// against a run-length model of loop behaviour.
module tb_vehicle_sense_cond;
  localparam int DEB   = 3;
  localparam int HOLD  = 4;
  localparam int STUCK = 60;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       loop_n, loop_e, loop_s, loop_w;
  logic       clr_cnt;
  logic       sensor_north, sensor_east, sensor_south, sensor_west;
  logic [7:0] veh_cnt_n, veh_cnt_e, veh_cnt_s, veh_cnt_w;
  logic [3:0] fault;

  int vectors     = 0;
  int miscompares = 0;

  // Model: runs of consecutive on/off samples per approach.
  int ones_run  [4];
  int zeros_run [4];
  int on_time   [4];
  int cnt       [4];
  bit present   [4];
  bit faulty    [4];

  always #5 clk = ~clk;

  vehicle_sense_cond #(.DEB(DEB), .HOLD(HOLD), .STUCK(STUCK)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .loop_n       (loop_n),
    .loop_e       (loop_e),
    .loop_s       (loop_s),
    .loop_w       (loop_w),
    .clr_cnt      (clr_cnt),
    .sensor_north (sensor_north),
    .sensor_east  (sensor_east),
    .sensor_south (sensor_south),
    .sensor_west  (sensor_west),
    .veh_cnt_n    (veh_cnt_n),
    .veh_cnt_e    (veh_cnt_e),
    .veh_cnt_s    (veh_cnt_s),
    .veh_cnt_w    (veh_cnt_w),
    .fault        (fault)
  );

  function automatic logic [39:0] obs_vec();
    return {sensor_west, sensor_south, sensor_east, sensor_north, fault,
            veh_cnt_w, veh_cnt_s, veh_cnt_e, veh_cnt_n};
  endfunction

  function automatic logic [39:0] exp_vec();
    logic [3:0] s;
    logic [3:0] f;
    for (int c = 0; c < 4; c++) begin
      s[c] = present[c] | faulty[c];
      f[c] = faulty[c];
    end
    return {s, f, 8'(cnt[3]), 8'(cnt[2]), 8'(cnt[1]), 8'(cnt[0])};
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 4; c++) begin
      ones_run[c] = 0; zeros_run[c] = 0; on_time[c] = 0; cnt[c] = 0;
      present[c] = 1'b0; faulty[c] = 1'b0;
    end
  endtask

  task automatic model_step(input logic t, input logic [3:0] r, input logic c);
    bit arr;
    for (int ch = 0; ch < 4; ch++) begin
      arr = 1'b0;
      if (t) begin
        if (faulty[ch]) begin
          if (r[ch]) zeros_run[ch] = 0;
          else begin
            zeros_run[ch]++;
            if (zeros_run[ch] == DEB) begin
              faulty[ch] = 1'b0; present[ch] = 1'b0;
              zeros_run[ch] = 0; on_time[ch] = 0; ones_run[ch] = 0;
            end
          end
        end else if (present[ch]) begin
          if (r[ch]) begin
            if (zeros_run[ch] > 0) zeros_run[ch] = 0;
            else begin
              on_time[ch]++;
              if (on_time[ch] == STUCK) begin
                faulty[ch] = 1'b1; zeros_run[ch] = 0;
              end
            end
          end else begin
            zeros_run[ch]++;
            if (zeros_run[ch] == HOLD) begin
              present[ch] = 1'b0; zeros_run[ch] = 0; on_time[ch] = 0;
            end
          end
        end else begin
          if (r[ch]) begin
            ones_run[ch]++;
            if (ones_run[ch] == DEB) begin
              present[ch] = 1'b1; ones_run[ch] = 0; on_time[ch] = 0;
              zeros_run[ch] = 0; arr = 1'b1;
            end
          end else begin
            ones_run[ch] = 0;
          end
        end
      end
      if (c) cnt[ch] = 0;
      else if (arr && cnt[ch] < 255) cnt[ch]++;
    end
  endtask

  // Driver: apply one clock's inputs, then advance the model past the edge.
  task automatic cycle(input logic t, input logic [3:0] r, input logic c);
    tick = t;
    {loop_w, loop_s, loop_e, loop_n} = r;
    clr_cnt = c;
    @(posedge clk);
    #1;
    model_step(t, r, c);
  endtask

  // One sample per four clocks; raw lines wander in between samples.
  task automatic slow_tick(input logic [3:0] r);
    cycle(1'b1, r, 1'b0);
    repeat (3) cycle(1'b0, 4'($urandom_range(0, 15)), 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1; tick = 1'b0; clr_cnt = 1'b0;
    {loop_w, loop_s, loop_e, loop_n} = 4'b0000;
    model_reset();
    #1;
    vectors++;
    if (obs_vec() !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_async: got %h exp %h", obs_vec(), 40'd0);
    end
    tick = 1'b1;
    {loop_w, loop_s, loop_e, loop_n} = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (obs_vec() !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_held: got %h exp %h", obs_vec(), 40'd0);
    end
    @(negedge clk);
    rst = 1'b0; tick = 1'b0;
    {loop_w, loop_s, loop_e, loop_n} = 4'b0000;
  endtask

  task automatic test_qualify();
    for (int k = 1; k <= 3; k++) begin
      slow_tick(4'b0001);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL qualify_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({sensor_north, veh_cnt_n, sensor_east, sensor_south, sensor_west} !== {1'b1, 8'd1, 3'b000}) begin
      miscompares++;
      $display("FAIL qualify_north: got %b/%0d others %b exp 1/1 others 000",
               sensor_north, veh_cnt_n, {sensor_east, sensor_south, sensor_west});
    end
    repeat (HOLD) slow_tick(4'b0000);
    vectors++;
    if (obs_vec() !== exp_vec()) begin
      miscompares++;
      $display("FAIL qualify_release: got %h exp %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 5; k++) begin
      slow_tick((k < 2) ? 4'b0010 : 4'b0000);
      vectors++;
      if (obs_vec() !== exp_vec() || sensor_east !== 1'b0 || veh_cnt_e !== 8'd0) begin
        miscompares++;
        $display("FAIL glitch_east_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_gap();
    repeat (3) slow_tick(4'b0100);
    for (int k = 0; k < 4; k++) begin
      slow_tick((k < 3) ? 4'b0000 : 4'b0100);
      vectors++;
      if (obs_vec() !== exp_vec() || sensor_south !== 1'b1 || veh_cnt_s !== 8'd1) begin
        miscompares++;
        $display("FAIL gap_hold_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    for (int k = 1; k <= 4; k++) begin
      slow_tick(4'b0000);
      vectors++;
      if (obs_vec() !== exp_vec() || sensor_south !== (k < 4)) begin
        miscompares++;
        $display("FAIL gap_drop_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_stuck();
    for (int k = 1; k <= DEB + STUCK; k++) begin
      slow_tick(4'b1000);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stuck_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({fault, sensor_west} !== {4'b1000, 1'b1}) begin
      miscompares++;
      $display("FAIL stuck_flag: got fault=%b west=%b exp fault=1000 west=1", fault, sensor_west);
    end
    for (int k = 1; k <= DEB; k++) begin
      slow_tick(4'b0000);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL stuck_clear_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    vectors++;
    if ({fault, sensor_west} !== 5'b0) begin
      miscompares++;
      $display("FAIL stuck_cleared: got fault=%b west=%b exp fault=0000 west=0", fault, sensor_west);
    end
  endtask

  task automatic test_saturate();
    cycle(1'b0, 4'b0000, 1'b1);
    for (int a = 1; a <= 256; a++) begin
      repeat (DEB) cycle(1'b1, 4'b0001, 1'b0);
      repeat (HOLD) cycle(1'b1, 4'b0000, 1'b0);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL saturate_arrival%0d: got %h exp %h", a, obs_vec(), exp_vec());
      end
      if (a == 255 || a == 256) begin
        vectors++;
        if (veh_cnt_n !== 8'd255) begin
          miscompares++;
          $display("FAIL saturate_n%0d: got %0d exp 255", a, veh_cnt_n);
        end
      end
    end
    repeat (DEB - 1) cycle(1'b1, 4'b0010, 1'b0);
    cycle(1'b1, 4'b0010, 1'b1);
    vectors++;
    if (obs_vec() !== exp_vec() || {veh_cnt_n, veh_cnt_e, veh_cnt_s, veh_cnt_w} !== 32'd0
        || sensor_east !== 1'b1) begin
      miscompares++;
      $display("FAIL clr_with_arrival: got %h exp %h", obs_vec(), exp_vec());
    end
    repeat (HOLD) cycle(1'b1, 4'b0000, 1'b0);
  endtask

  task automatic test_async_reset_gap();
    repeat (DEB) slow_tick(4'b1111);
    slow_tick(4'b0000);
    vectors++;
    if (obs_vec() !== exp_vec() || {sensor_west, sensor_south, sensor_east, sensor_north} !== 4'b1111) begin
      miscompares++;
      $display("FAIL gap_before_reset: got %h exp %h", obs_vec(), exp_vec());
    end
    #2 rst = 1'b1;
    #1;
    model_reset();
    vectors++;
    if (obs_vec() !== 40'd0) begin
      miscompares++;
      $display("FAIL reset_mid_gap: got %h exp %h", obs_vec(), 40'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 1; k <= DEB; k++) begin
      slow_tick(4'b1111);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL requalify_tick%0d: got %h exp %h", k, obs_vec(), exp_vec());
      end
    end
    repeat (HOLD) slow_tick(4'b0000);
  endtask

  task automatic test_random();
    logic [3:0] lvl;
    logic       t;
    logic       c;
    lvl = 4'b0000;
    for (int n = 0; n < 1500; n++) begin
      for (int ch = 0; ch < 4; ch++)
        if ($urandom_range(0, 7) == 0) lvl[ch] = ~lvl[ch];
      t = ($urandom_range(0, 2) != 0);
      c = ($urandom_range(0, 99) == 0);
      cycle(t, lvl, c);
      vectors++;
      if (obs_vec() !== exp_vec()) begin
        miscompares++;
        $display("FAIL random_cycle%0d: got %h exp %h", n, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_qualify();
    test_glitch();
    test_gap();
    test_stuck();
    test_saturate();
    test_async_reset_gap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
